// File: rtl/clr_release_seq.sv
// Sequenced release of active-low async clears for NUM_GRP flop banks.
// Clears assert asynchronously on CD; release is synchronized, held, then staggered per bank.
module clr_release_seq #(
  parameter int NUM_GRP     = 4,
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 8,
  parameter int GAP_CYC     = 2
) (
  input  logic               CP,
  input  logic               CD,
  input  logic               clr_req,
  output logic               clr_ack,
  output logic [NUM_GRP-1:0] cdn_out,
  output logic               busy,
  output logic               done
);

  localparam int MAX_CYC = (HOLD_CYC > GAP_CYC) ? HOLD_CYC : GAP_CYC;
  localparam int CW      = $clog2(MAX_CYC + 1);
  localparam int GW      = $clog2(NUM_GRP) + 1;

  generate
    if (NUM_GRP < 1) begin : g_bad_num_grp
      $error("clr_release_seq: NUM_GRP must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
      $error("clr_release_seq: SYNC_STAGES must be >= 2");
    end
    if (HOLD_CYC < 1) begin : g_bad_hold
      $error("clr_release_seq: HOLD_CYC must be >= 1");
    end
    if (GAP_CYC < 1) begin : g_bad_gap
      $error("clr_release_seq: GAP_CYC must be >= 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_SYNC = 2'd0,
    ST_HOLD = 2'd1,
    ST_REL  = 2'd2,
    ST_IDLE = 2'd3
  } state_t;

  logic [SYNC_STAGES-1:0] sync_r;
  state_t                 state_r, state_s;
  logic [CW-1:0]          cnt_r, cnt_s;
  logic [GW-1:0]          grp_r, grp_s;
  logic [NUM_GRP-1:0]     cdn_r, cdn_s;
  logic                   busy_r, busy_s;
  logic                   done_r, done_s;
  logic                   ack_r, ack_s;

  // Reset-release synchronizer: clears instantly, fills with ones after CD falls
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      sync_r <= '0;
    end else begin
      sync_r <= {sync_r[SYNC_STAGES-2:0], 1'b1};
    end
  end

  // Next-state and next-output logic; every output is re-registered below
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    grp_s   = grp_r;
    cdn_s   = cdn_r;
    busy_s  = busy_r;
    done_s  = 1'b0;
    ack_s   = 1'b0;
    case (state_r)
      ST_SYNC: begin
        if (sync_r[SYNC_STAGES-1]) begin
          state_s = ST_HOLD;
          cnt_s   = '0;
        end else begin
          state_s = ST_SYNC;
        end
      end
      ST_HOLD: begin
        if (cnt_r == CW'(HOLD_CYC - 1)) begin
          cdn_s[0] = 1'b1;
          cnt_s    = '0;
          grp_s    = GW'(1);
          if (NUM_GRP == 1) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = ST_REL;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_REL: begin
        if (cnt_r == CW'(GAP_CYC - 1)) begin
          // Only the bank selected by grp is added, keeping cdn a thermometer
          for (int i = 0; i < NUM_GRP; i++) begin
            cdn_s[i] = cdn_r[i] | (grp_r == GW'(i));
          end
          grp_s = grp_r + GW'(1);
          cnt_s = '0;
          if (grp_r == GW'(NUM_GRP - 1)) begin
            state_s = ST_IDLE;
            done_s  = 1'b1;
            busy_s  = 1'b0;
          end else begin
            state_s = ST_REL;
          end
        end else begin
          cnt_s = cnt_r + CW'(1);
        end
      end
      ST_IDLE: begin
        if (clr_req) begin
          cdn_s   = '0;
          busy_s  = 1'b1;
          ack_s   = 1'b1;
          cnt_s   = '0;
          state_s = ST_HOLD;
        end else begin
          cdn_s  = '1;
          busy_s = 1'b0;
        end
      end
      default: begin
        state_s = ST_SYNC;
        cdn_s   = '0;
        busy_s  = 1'b1;
        cnt_s   = '0;
        grp_s   = '0;
      end
    endcase
  end

  // State and output registers; CD forces every bank clear immediately
  always_ff @(posedge CP or posedge CD) begin
    if (CD) begin
      state_r <= ST_SYNC;
      cnt_r   <= '0;
      grp_r   <= '0;
      cdn_r   <= '0;
      busy_r  <= 1'b1;
      done_r  <= 1'b0;
      ack_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      grp_r   <= grp_s;
      cdn_r   <= cdn_s;
      busy_r  <= busy_s;
      done_r  <= done_s;
      ack_r   <= ack_s;
    end
  end

  assign cdn_out = cdn_r;
  assign busy    = busy_r;
  assign done    = done_r;
  assign clr_ack = ack_r;

endmodule

// File: tb/tb_clr_release_seq.sv
// Bench for clr_release_seq: default instance plus two corner-parameter instances,
// checked every cycle against a release-schedule model and by literal expectations.
module tb_clr_release_seq;

  logic CP = 1'b0;
  logic CD;
  logic clr_req = 1'b0;

  logic       ack0, busy0, done0;
  logic [3:0] cdn0;
  logic       ack1, busy1, done1;
  logic [0:0] cdn1;
  logic       ack2, busy2, done2;
  logic [3:0] cdn2;

  clr_release_seq u_dut (
    .CP(CP), .CD(CD), .clr_req(clr_req),
    .clr_ack(ack0), .cdn_out(cdn0), .busy(busy0), .done(done0)
  );

  clr_release_seq #(.NUM_GRP(1), .SYNC_STAGES(2), .HOLD_CYC(1), .GAP_CYC(1)) u_c1 (
    .CP(CP), .CD(CD), .clr_req(clr_req),
    .clr_ack(ack1), .cdn_out(cdn1), .busy(busy1), .done(done1)
  );

  clr_release_seq #(.NUM_GRP(4), .SYNC_STAGES(3), .HOLD_CYC(8), .GAP_CYC(2)) u_c2 (
    .CP(CP), .CD(CD), .clr_req(clr_req),
    .clr_ack(ack2), .cdn_out(cdn2), .busy(busy2), .done(done2)
  );

  always #10 CP = ~CP;

  int errors = 0;
  int checks = 0;

  int ng_a[3] = '{4, 1, 4};
  int ss_a[3] = '{2, 2, 3};
  int h_a[3]  = '{8, 1, 8};
  int g_a[3]  = '{2, 1, 2};

  logic [3:0] cdn_v[3];
  logic       ack_v[3], busy_v[3], done_v[3];
  assign cdn_v[0] = cdn0;
  assign cdn_v[1] = {3'b000, cdn1};
  assign cdn_v[2] = cdn2;
  assign ack_v[0] = ack0;  assign ack_v[1] = ack1;  assign ack_v[2] = ack2;
  assign busy_v[0] = busy0; assign busy_v[1] = busy1; assign busy_v[2] = busy2;
  assign done_v[0] = done0; assign done_v[1] = done1; assign done_v[2] = done2;

  task automatic chk(input string nm, input int idx, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d]: got %b expected %b at %0t", nm, idx, act, exp, $time);
    end
  endtask

  function automatic logic is_therm(input logic [3:0] v);
    return (v == 4'b0000) || (v == 4'b0001) || (v == 4'b0011) || (v == 4'b0111) || (v == 4'b1111);
  endfunction

  // Model: absolute edge numbers of first and last bank release per instance
  int e_r = 0;
  int cd_rises = 0;
  int seen = 0;
  int fr[3] = '{0, 0, 0};
  int lr[3] = '{0, 0, 0};
  bit pend[3] = '{1'b1, 1'b1, 1'b1};
  bit ack_m[3] = '{1'b0, 1'b0, 1'b0};

  always @(posedge CD) cd_rises <= cd_rises + 1;

  always @(posedge CP) begin
    int en;
    int span;
    en = e_r + 1;
    for (int i = 0; i < 3; i++) begin
      span = (ng_a[i] - 1) * g_a[i];
      if (CD) begin
        pend[i]  <= 1'b1;
        ack_m[i] <= 1'b0;
      end else if (pend[i] || cd_rises != seen) begin
        // this edge is edge 1 after release; bank 0 goes at edge SS+1+HOLD
        pend[i]  <= 1'b0;
        fr[i]    <= en + ss_a[i] + h_a[i];
        lr[i]    <= en + ss_a[i] + h_a[i] + span;
        ack_m[i] <= 1'b0;
      end else if (en > lr[i] && clr_req) begin
        fr[i]    <= en + h_a[i];
        lr[i]    <= en + h_a[i] + span;
        ack_m[i] <= 1'b1;
      end else begin
        ack_m[i] <= 1'b0;
      end
    end
    seen <= cd_rises;
    e_r  <= en;
  end

  // Compare every instance against the model on each falling edge
  always @(negedge CP) begin
    logic [3:0] ec;
    logic eb, ed, ea;
    for (int i = 0; i < 3; i++) begin
      ec = 4'b0000;
      if (CD || pend[i] || cd_rises != seen) begin
        eb = 1'b1; ed = 1'b0; ea = 1'b0;
      end else begin
        for (int k = 0; k < ng_a[i]; k++) ec[k] = (e_r >= fr[i] + k * g_a[i]);
        eb = (e_r < lr[i]);
        ed = (e_r == lr[i]);
        ea = ack_m[i];
      end
      chk("cdn", i, cdn_v[i], ec);
      chk("busy", i, {3'b000, busy_v[i]}, {3'b000, eb});
      chk("done", i, {3'b000, done_v[i]}, {3'b000, ed});
      chk("ack", i, {3'b000, ack_v[i]}, {3'b000, ea});
      chk("done_ack", i, {3'b000, done_v[i] & ack_v[i]}, 4'b0000);
    end
    chk("therm", 0, {3'b000, is_therm(cdn0)}, 4'b0001);
  end

  task automatic wait_edges(input int n);
    repeat (n) @(posedge CP);
    #1;
  endtask

  initial begin
    int acks;
    bit found;
    CD = 1'b1;
    wait_edges(3);
    CD = 1'b0;

    // Release after CD: edge counting starts at the next CP rise
    wait_edges(3);  chk("c1_e3", 1, {3'b000, cdn1}, 4'b0000);
    wait_edges(1);  chk("c1_e4", 1, {3'b000, cdn1}, 4'b0001);
                    chk("c1_done_e4", 1, {3'b000, done1}, 4'b0001);
    wait_edges(1);  chk("c1_done_e5", 1, {3'b000, done1}, 4'b0000);
    wait_edges(5);  chk("rst_e10", 0, cdn0, 4'b0000);
                    chk("busy_e10", 0, {3'b000, busy0}, 4'b0001);
    wait_edges(1);  chk("rel_e11", 0, cdn0, 4'b0001);
                    chk("c2_e11", 2, cdn2, 4'b0000);
    wait_edges(1);  chk("c2_e12", 2, cdn2, 4'b0001);
    wait_edges(1);  chk("rel_e13", 0, cdn0, 4'b0011);
    wait_edges(4);  chk("rel_e17", 0, cdn0, 4'b1111);
                    chk("done_e17", 0, {3'b000, done0}, 4'b0001);
                    chk("busy_e17", 0, {3'b000, busy0}, 4'b0000);
    wait_edges(1);  chk("done_e18", 0, {3'b000, done0}, 4'b0000);
                    chk("c2_done_e18", 2, {3'b000, done2}, 4'b0001);

    // Single-edge software clear
    wait_edges(2);
    clr_req = 1'b1;
    wait_edges(1);  chk("ack_A", 0, {3'b000, ack0}, 4'b0001);
                    chk("clr_A", 0, cdn0, 4'b0000);
    clr_req = 1'b0;
    wait_edges(7);  chk("clr_A7", 0, cdn0, 4'b0000);
    wait_edges(1);  chk("clr_A8", 0, cdn0, 4'b0001);
    wait_edges(6);  chk("clr_A14", 0, cdn0, 4'b1111);
                    chk("done_A14", 0, {3'b000, done0}, 4'b0001);
    wait_edges(1);

    // Request held: accepted every 15 edges, never while busy
    clr_req = 1'b1;
    acks = 0;
    for (int n = 0; n < 45; n++) begin
      wait_edges(1);
      if (ack0) acks++;
    end
    chk("held_acks", 0, 4'(acks), 4'd3);
    clr_req = 1'b0;

    // CD glitch in the middle of the release phase
    wait_edges(1);
    clr_req = 1'b1;
    wait_edges(1);
    clr_req = 1'b0;
    found = 1'b0;
    for (int n = 0; n < 40 && !found; n++) begin
      wait_edges(1);
      if (cdn0 == 4'b0011) found = 1'b1;
    end
    chk("reach_0011", 0, {3'b000, found}, 4'b0001);
    #1 CD = 1'b1;
    #1 chk("glitch_cdn", 0, cdn0, 4'b0000);
       chk("glitch_busy", 0, {3'b000, busy0}, 4'b0001);
    #1 CD = 1'b0;
    wait_edges(10); chk("re_e10", 0, cdn0, 4'b0000);
    wait_edges(1);  chk("re_e11", 0, cdn0, 4'b0001);
    wait_edges(6);  chk("re_e17", 0, cdn0, 4'b1111);

    // Random request and CD traffic
    for (int n = 0; n < 400; n++) begin
      wait_edges(1);
      clr_req = 1'($urandom_range(0, 1));
      if ($urandom_range(0, 29) == 0) begin
        #1 CD = 1'b1;
        #(2 + 20 * $urandom_range(0, 2)) CD = 1'b0;
      end
    end
    clr_req = 1'b0;
    wait_edges(40);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
